// File: rtl/text_fetch_pkg.sv
// Shared types and constants for the text_fetch character-code feeder.
package text_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } fetch_state_t;

  localparam int COLS_32      = 32;
  localparam int COLS_64      = 64;
  localparam int CELL_LAST_32 = 15;
  localparam int CELL_LAST_64 = 7;

  localparam logic [7:0] FILL_CODE_DEF = 8'h20;

  function automatic logic [3:0] cell_last_of(input logic w64);
    return w64 ? 4'(CELL_LAST_64) : 4'(CELL_LAST_32);
  endfunction

endpackage

// File: rtl/text_pos_counter.sv
// Screen position counters for text_fetch: pixel-in-cell, column, scanline-in-row
// and row, plus the cell wrap strobe that paces fetches and char_code updates.
module text_pos_counter
  import text_fetch_pkg::*;
#(
  parameter int LINES_PER_ROW = 12,
  parameter int ROWS          = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       line_start,
  input  logic       width_64,
  output logic [3:0] pixel,
  output logic [6:0] col,
  output logic [4:0] sub_line,
  output logic [4:0] row,
  output logic       w64,
  output logic       running,
  output logic       lead_in,
  output logic       cell_wrap,
  output logic       last_col
);

  logic       frame_done;
  logic [3:0] cell_last;

  assign cell_last = cell_last_of(w64);
  assign cell_wrap = running && (pixel == cell_last);
  assign last_col  = (col == (w64 ? 7'(COLS_64 - 1) : 7'(COLS_32 - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pixel      <= '0;
      col        <= '0;
      sub_line   <= '0;
      row        <= '0;
      w64        <= 1'b0;
      running    <= 1'b0;
      lead_in    <= 1'b0;
      frame_done <= 1'b0;
    end else if (frame_start) begin
      // Column mode is only ever latched here so a frame never mixes widths.
      sub_line   <= '0;
      row        <= '0;
      w64        <= width_64;
      frame_done <= 1'b0;
      running    <= 1'b0;
      lead_in    <= 1'b0;
      pixel      <= '0;
      col        <= '0;
    end else if (line_start && !frame_done) begin
      running <= 1'b1;
      lead_in <= 1'b1;
      pixel   <= '0;
      col     <= '0;
    end else if (running) begin
      if (!cell_wrap) begin
        pixel <= pixel + 4'd1;
      end else begin
        pixel <= '0;
        if (lead_in) begin
          // The lead-in cell only prefetches column 0; col stays put.
          lead_in <= 1'b0;
        end else begin
          col <= col + 7'd1;
          if (last_col) begin
            running <= 1'b0;
            if (sub_line == 5'(LINES_PER_ROW - 1)) begin
              sub_line <= '0;
              row      <= row + 5'd1;
              if (row == 5'(ROWS - 1)) frame_done <= 1'b1;
            end else begin
              sub_line <= sub_line + 5'd1;
            end
          end
        end
      end
    end
  end

endmodule

// File: rtl/text_fetch.sv
// Text-mode fetch front end: walks the screen, reads codes from video RAM one cell
// ahead and feeds the character generator. Optional TEXT_FETCH_STATS_EN adds underrun_count.
module text_fetch
  import text_fetch_pkg::*;
#(
  parameter int         ADDR_W        = 11,
  parameter int         LINES_PER_ROW = 12,
  parameter int         ROWS          = 16,
  parameter logic [7:0] FILL_CODE     = FILL_CODE_DEF
) (
  input  logic              pixel_clock,
  input  logic              reset_n,
  input  logic              width_64,
  input  logic              frame_start,
  input  logic              line_start,
  output logic [ADDR_W-1:0] vram_addr,
  output logic              vram_rd_req,
  input  logic              vram_rd_ack,
  input  logic [7:0]        vram_data,
  output logic [7:0]        char_code,
  output logic [4:0]        subchar_line,
  output logic [3:0]        subchar_pixel,
  output logic              display_active,
`ifdef TEXT_FETCH_STATS_EN
  output logic [7:0]        underrun_count,
`endif
  output fetch_state_t      fetch_state,
  output logic              underrun
);

  // VRAM port: vram_rd_req rises with a stable vram_addr and holds until the
  // single-cycle vram_rd_ack (data valid that cycle) or until the fetch is aborted.

  logic [3:0] pixel;
  logic [6:0] col;
  logic [4:0] sub_line;
  logic [4:0] row;
  logic       w64;
  logic       running;
  logic       lead_in;
  logic       cell_wrap;
  logic       last_col;

  text_pos_counter #(
    .LINES_PER_ROW (LINES_PER_ROW),
    .ROWS          (ROWS)
  ) u_pos (
    .clk         (pixel_clock),
    .rst_n       (reset_n),
    .frame_start (frame_start),
    .line_start  (line_start),
    .width_64    (width_64),
    .pixel       (pixel),
    .col         (col),
    .sub_line    (sub_line),
    .row         (row),
    .w64         (w64),
    .running     (running),
    .lead_in     (lead_in),
    .cell_wrap   (cell_wrap),
    .last_col    (last_col)
  );

  assign subchar_pixel  = pixel;
  assign subchar_line   = sub_line;
  assign display_active = running & ~lead_in;

  fetch_state_t      state;
  fetch_state_t      state_d;
  logic              req_d;
  logic [ADDR_W-1:0] addr_d;
  logic [7:0]        next_code;
  logic [7:0]        next_d;
  logic              abort;
  logic              fetch_needed;
  logic [6:0]        fetch_col;
  logic [ADDR_W-1:0] fetch_addr;
  logic              deadline;

  assign fetch_state  = state;
  assign fetch_needed = lead_in | ~last_col;
  assign fetch_col    = lead_in ? 7'd0 : col + 7'd1;
  assign fetch_addr   = ADDR_W'(row) * ADDR_W'(w64 ? COLS_64 : COLS_32) + ADDR_W'(fetch_col);
  // Last clock at which a late code can still reach next_code before the wrap.
  assign deadline     = (pixel == cell_last_of(w64) - 4'd1);

  always_comb begin
    state_d = state;
    req_d   = vram_rd_req;
    addr_d  = vram_addr;
    next_d  = next_code;
    abort   = 1'b0;
    case (state)
      IDLE: begin
        if (running && (pixel == 4'd0) && fetch_needed) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = fetch_addr;
        end
      end
      REQ, WAIT: begin
        if (vram_rd_ack) begin
          state_d = IDLE;
          req_d   = 1'b0;
          next_d  = vram_data;
        end else if ((state == WAIT) && deadline) begin
          state_d = IDLE;
          req_d   = 1'b0;
          next_d  = FILL_CODE;
          abort   = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
    if (frame_start) begin
      state_d = IDLE;
      req_d   = 1'b0;
      next_d  = next_code;
      abort   = 1'b0;
    end
  end

  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      vram_rd_req <= 1'b0;
      vram_addr   <= '0;
      next_code   <= FILL_CODE;
      char_code   <= '0;
      underrun    <= 1'b0;
    end else begin
      state       <= state_d;
      vram_rd_req <= req_d;
      vram_addr   <= addr_d;
      next_code   <= next_d;
      if (cell_wrap) char_code <= next_code;
      if (frame_start)  underrun <= 1'b0;
      else if (abort)   underrun <= 1'b1;
    end
  end

`ifdef TEXT_FETCH_STATS_EN
  always_ff @(posedge pixel_clock or negedge reset_n) begin
    if (!reset_n) begin
      underrun_count <= '0;
    end else if (abort && (underrun_count != 8'hFF)) begin
      underrun_count <= underrun_count + 8'd1;
    end
  end
`endif

endmodule

// File: doc/text_fetch.md
Name: text_fetch

Overview:
- Upstream feeder for the SVGA character generator.
- Walks the 32x16 or 64x16 text screen using line/frame strobes from the sync generator, reads character codes from video RAM through a request/acknowledge port, and presents char_code, subchar_line and subchar_pixel to the character generator.
- Prefetches one cell ahead so the code is stable before the generator latches ROM data at subchar_pixel 5.

Parameters:
- ADDR_W, 11, width of vram_addr; screen occupies offsets 0..1023.
- LINES_PER_ROW, 12, scanlines per character row.
- ROWS, 16, text rows per frame.
- FILL_CODE, 8'h20, code substituted when a fetch misses its deadline.

Ports:
- pixel_clock  in  1  sole clock.
- reset_n  in  1  asynchronous active-low reset.
- width_64  in  1  1 = 64 columns, 8-clock cells; 0 = 32 columns, 16-clock cells.
- frame_start  in  1  one-clock pulse before the first active line.
- line_start  in  1  one-clock pulse exactly one cell period before the first visible cell of each active line.
- vram_addr  out  ADDR_W  read address, row*cols+col.
- vram_rd_req  out  1  read request, held until ack or abort.
- vram_rd_ack  in  1  one-clock pulse; vram_data valid in the same cycle.
- vram_data  in  8  character code.
- char_code  out  8  code for the current cell.
- subchar_line  out  5  scanline within row, 0..LINES_PER_ROW-1.
- subchar_pixel  out  4  clock within cell: 0..15 in 32-column mode, 0..7 in 64-column mode.
- display_active  out  1  high while visible cells are being output.
- underrun  out  1  sticky; set on any aborted fetch, cleared by frame_start.

Behaviour:
- Reset: all outputs 0, FSM IDLE, all counters 0, next_code = FILL_CODE.
- frame_start:
  - row and subchar_line go to 0.
  - underrun clears.
  - Any in-flight request is dropped; req goes low next clock.
- line_start:
  - col goes to 0 and subchar_pixel to 0.
  - The lead-in cell begins: display_active = 0, fetch of col 0 starts.
- Pixel counter:
  - subchar_pixel increments every clock while a line is running.
  - Wraps at cell_last (15, or 7 if width_64).
- At each wrap:
  - char_code <= next_code.
  - display_active goes high after the lead-in cell.
  - col increments.
  - Once col == cols, the line ends: display_active = 0 and the counter stops.
- End of line: subchar_line increments. At LINES_PER_ROW-1 it wraps to 0 and row increments. Lines after row ROWS-1 are ignored until the next frame_start.
- Fetch FSM, one fetch per cell, for col+1 (col 0 during lead-in):
  - IDLE: at subchar_pixel==0, with a line running and a column still to fetch, go to REQ.
  - REQ: drive vram_addr and vram_rd_req = 1 registered (one-clock latency from the decision), then go to WAIT.
  - WAIT:
    - On ack: next_code <= vram_data, drop req, go to IDLE.
    - On deadline (subchar_pixel == cell_last-1) with no ack: drop req, next_code <= FILL_CODE, underrun <= 1, go to IDLE.
  - An ack arriving in the same cycle as the deadline counts as success.
- Address arithmetic: vram_addr = row*(width_64?64:32) + col, truncated to ADDR_W.
- width_64 is sampled only at frame_start; a mid-frame change has no effect until then.
- Reset mid-fetch: req drops asynchronously.

Optional Feature:
- Macro: TEXT_FETCH_STATS_EN.
- When defined: adds output underrun_count[7:0], which counts aborted fetches, saturates at 255, and clears at reset only.
- When undefined: the port and counter are absent; only the sticky underrun flag remains.

Decomposition:
- Shared package holds:
  - fetch FSM state typedef (IDLE, REQ, WAIT);
  - COLS_32 = 32 and COLS_64 = 64;
  - CELL_LAST_32 = 15 and CELL_LAST_64 = 7;
  - FILL_CODE default.
- One natural sub-module, text_pos_counter: pixel/col/line/row counters and their wrap strobes. The fetch FSM and output registers stay in the top.

Test Plan:
- Reset, then frame_start, width_64=0, line_start, ack always one clock after req with data = col+8'h40.
  - vram_addr 0,1,…,31.
  - char_code reads 8'h40 during the first visible cell, 8'h41 in the next, and so on.
  - display_active is high for exactly 512 clocks.
- Run 13 lines.
  - subchar_line counts 0..11, then 0.
  - row 1 fetch address begins at 32.
- width_64=1 at frame_start.
  - Cells are 8 clocks; subchar_pixel 0..7.
  - Row 2, col 5 address = 133.
- Withhold ack for cell 3 until past subchar_pixel 14.
  - req drops at 14.
  - Code 8'h20 is shown in cell 3; underrun = 1 until the next frame_start.
  - With TEXT_FETCH_STATS_EN defined, underrun_count = 1.
- Ack coincident with deadline cycle: data is accepted, underrun stays 0.
- Assert reset_n low while req is high: all outputs 0 asynchronously; after release, no req until the next line_start.
